// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - peripheral bus between the bridge and one timer instance
interface timer_counter_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (
    output Addr,
    output WE,
    output Din,
    input  Dout,
    input  IRQ
  );

  modport slave (
    input  Addr,
    input  WE,
    input  Din,
    output Dout,
    output IRQ
  );
endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped countdown timer with one-shot / auto-reload modes
module timer_counter (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic enable;
  logic auto_reload;
  logic irq_mask;

  assign enable      = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign irq_mask    = ctrl[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ctrl     <= 4'h0;
      preset   <= 32'h0;
      count    <= 32'h0;
      irq_flag <= 1'b0;
    end else begin
      // Auto-reload turns the flag into a single-cycle pulse.
      if (auto_reload && irq_flag) begin
        irq_flag <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (enable) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count <= 32'h0;
            state <= S_INT;
          end
        end
        S_INT: begin
          irq_flag <= 1'b1;
          if (!auto_reload) begin
            ctrl[0] <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Bus writes come last so they win over the FSM's own updates.
      if (bus.WE && bus.Addr == 2'b00) begin
        ctrl     <= bus.Din[3:0];
        irq_flag <= 1'b0;
      end else if (bus.WE && bus.Addr == 2'b01) begin
        preset   <= bus.Din;
        irq_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.Dout = 32'h0;
    case (bus.Addr)
      2'b00:   bus.Dout = {28'h0, ctrl};
      2'b01:   bus.Dout = preset;
      2'b10:   bus.Dout = count;
      default: bus.Dout = 32'h0;
    endcase
  end

  assign bus.IRQ = irq_flag & irq_mask;
endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped countdown timer. It is the responder on the CPU/bridge peripheral bus, the slave end of the bridge read path that returns PrRD.
- Two instances are used, at 0x7f00 and 0x7f10. The bridge decodes the base address and supplies only the word offset, WE and write data.
- The block returns read data combinationally and raises an interrupt request toward CP0.

Parameters:
- None. The register map and all widths are fixed at 32 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Addr  input  2  word offset (byte address bits [3:2]): 00=CTRL, 01=PRESET, 10=COUNT, 11=unused
- WE  input  1  write enable from bridge; sampled at rising edge
- Din  input  32  write data
- Dout  output  32  read data, combinational from Addr
- IRQ  output  1  interrupt request

Behaviour:
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. Dout follows the reset register values. IRQ=0.
- CTRL register fields:
  - bit0 Enable
  - bits[2:1] Mode: 01 = auto-reload; every other value = one-shot (mode 0)
  - bit3 IM (interrupt mask, 1 = allow)
  - Bits [31:4] are not stored and read as 0.
- Writes:
  - WE & Addr=00: CTRL[3:0] <= Din[3:0].
  - WE & Addr=01: PRESET <= Din.
  - Writes to Addr 10 or 11 are ignored.
  - Any write to CTRL or PRESET clears irq_flag.
- Reads: Dout = {28'b0,CTRL} / PRESET / COUNT / 32'h0 for Addr 00/01/10/11.
- IRQ = irq_flag & CTRL.IM, purely combinational.
- FSM states IDLE, LOAD, CNT, INT, with transitions at each edge:
  - IDLE: if Enable, go to LOAD; else stay. COUNT holds.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT:
    - If Enable=0, go to IDLE and hold COUNT.
    - Else if COUNT>1, COUNT <= COUNT-1.
    - Else (COUNT is 0 or 1), COUNT <= 0 and go to INT.
  - INT: irq_flag <= 1, go to IDLE.
    - Mode 0 additionally clears CTRL.Enable, so the timer stops and irq_flag stays high until a CTRL/PRESET write.
    - Mode 1 keeps Enable. irq_flag auto-clears on the edge after it is set, giving a 1-cycle pulse. The FSM then re-enters LOAD, reloading PRESET.
- Timing for PRESET=N≥1, counting edges from the edge that writes Enable=1 (edge 0):
  - LOAD at edge 1, COUNT=N after edge 2.
  - COUNT=1 after edge N+1, INT entered at edge N+2.
  - irq_flag=1 after edge N+3.
  - Mode 1 period is N+3 cycles.
- PRESET=0 behaves like PRESET=1 except that COUNT reads 0 during CNT.
- Simultaneous events:
  - A CPU CTRL write in the same cycle the FSM clears Enable (INT, mode 0): the CPU write wins.
  - A CTRL/PRESET write on the same edge as an irq_flag set: the clear wins, so the flag stays 0.
  - A PRESET write mid-count does not change COUNT; it takes effect at the next LOAD.
  - Writing Enable=0 in INT: the INT actions still occur; the FSM then stays IDLE.
- COUNT never wraps below 0; all arithmetic is 32-bit unsigned.
- Reset asserted in any state forces reset values at that edge and overrides WE.

Test Plan:
- Reset then read Addr 00/01/10/11 -> Dout=0 each, IRQ=0. Write CTRL=32'hFFFF_FFFF -> CTRL reads 32'h0000_000F.
- PRESET=5, CTRL=32'h9 (mode 0, IM=1, enable) -> COUNT reads 5,4,3,2,1,0 after edges 2..7. IRQ rises after edge 8 and stays high. CTRL reads 32'h8. Writing PRESET=5 drops IRQ next cycle.
- PRESET=3, CTRL=32'hB (mode 1, IM=1) -> IRQ is a 1-cycle pulse every 6 cycles for ≥3 periods. CTRL.Enable remains 1.
- Mode 0, IM=0, PRESET=2 -> IRQ stays 0 throughout. Then write CTRL=32'h8: this write clears irq_flag, so IRQ remains 0.
- Counting with COUNT=100, write CTRL Enable=0 -> COUNT freezes at its value and the FSM goes IDLE. Re-enable -> COUNT reloads PRESET, not a resume.
- Assert reset mid-CNT with WE=1 writing PRESET -> all registers 0, IRQ=0, and the write is discarded.
